// File: rtl/motor_pkg.sv
// Shared types for the motor driver: command encodings (common with the robot FSM),
// per-wheel FSM states and direction constants.
package motor_pkg;

    typedef enum logic [4:0] {
        MS_STOP    = 5'b00001,
        MS_FORWARD = 5'b00010,
        MS_RIGHT   = 5'b00100,
        MS_LEFT    = 5'b01000,
        MS_SPIN    = 5'b10000
    } motor_state_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        BRAKE = 2'd1,
        DEAD  = 2'd2
    } wheel_state_t;

    typedef struct packed {
        wheel_state_t left;
        wheel_state_t right;
    } wheel_dbg_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/motor_channel.sv
// One wheel: ramps duty toward its target, and on a direction change brakes to zero
// and sits out a dead-time before latching the new direction.
module motor_channel
    import motor_pkg::*;
#(
    parameter int PWM_BITS         = 8,
    parameter int STEP             = 8,
    parameter int DEADTIME_PERIODS = 4
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                period_end,
    input  logic                force_stop,
    input  logic                target_dir,
    input  logic [PWM_BITS-1:0] target_duty,
    output logic                dir,
    output logic [PWM_BITS-1:0] duty,
    output wheel_state_t        state
);

    localparam int DC_W = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS + 1) : 1;
    localparam logic [DC_W-1:0]     DC_LAST = DC_W'(DEADTIME_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] STEP_V  = PWM_BITS'(STEP);

    logic [DC_W-1:0] dead_cnt;

    // Differences are taken before comparing so the step never wraps or overshoots.
    function automatic logic [PWM_BITS-1:0] approach(input logic [PWM_BITS-1:0] cur,
                                                     input logic [PWM_BITS-1:0] tgt);
        if (tgt > cur)
            return ((tgt - cur) > STEP_V) ? cur + STEP_V : tgt;
        return ((cur - tgt) > STEP_V) ? cur - STEP_V : tgt;
    endfunction

    function automatic logic [PWM_BITS-1:0] brake(input logic [PWM_BITS-1:0] cur);
        return (cur > STEP_V) ? cur - STEP_V : '0;
    endfunction

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            dir      <= DIR_FWD;
            duty     <= '0;
            dead_cnt <= '0;
        end else if (force_stop) begin
            state <= RUN;
            duty  <= '0;
        end else if (period_end) begin
            case (state)
                RUN: begin
                    if (target_dir == dir) begin
                        duty <= approach(duty, target_duty);
                    end else begin
                        duty     <= brake(duty);
                        dead_cnt <= '0;
                        state    <= (duty <= STEP_V) ? DEAD : BRAKE;
                    end
                end
                BRAKE: begin
                    if (target_dir == dir) begin
                        state <= RUN;
                        duty  <= approach(duty, target_duty);
                    end else begin
                        duty <= brake(duty);
                        if (duty <= STEP_V) begin
                            state    <= DEAD;
                            dead_cnt <= '0;
                        end
                    end
                end
                DEAD: begin
                    if (target_dir == dir) begin
                        state <= RUN;
                        duty  <= approach(duty, target_duty);
                    end else if (dead_cnt == DC_LAST) begin
                        // Duty stays 0 for this period; ramping starts at the next one.
                        dir   <= target_dir;
                        state <= RUN;
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: rtl/motor_pwm_driver.sv
// Turns the one-hot motor_state command into per-wheel PWM and direction.
// MOTOR_RAMP_EN defined: duty ramps by RAMP_STEP per period; undefined: duty jumps to target.
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int CLKS_PER_TICK    = 50,
    parameter int PWM_BITS         = 8,
    parameter int SPEED_FWD        = 200,
    parameter int SPEED_TURN       = 140,
    parameter int SPEED_SPIN       = 120,
    parameter int RAMP_STEP        = 8,
    parameter int DEADTIME_PERIODS = 4
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [4:0]          motor_state,
    output logic                pwm_l,
    output logic                pwm_r,
    output logic                dir_l,
    output logic                dir_r,
    output logic [PWM_BITS-1:0] duty_l,
    output logic [PWM_BITS-1:0] duty_r,
    output logic                fault,
    output wheel_dbg_t          wheel_dbg
);

`ifdef MOTOR_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif
    // A full-scale step makes the channel jump straight to target and skip BRAKE.
    localparam int STEP = RAMP_EN ? RAMP_STEP : (1 << PWM_BITS) - 1;

    localparam int PRESC_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLKS_PER_TICK - 1);

    localparam logic [PWM_BITS-1:0] D_FWD  = PWM_BITS'(SPEED_FWD);
    localparam logic [PWM_BITS-1:0] D_TURN = PWM_BITS'(SPEED_TURN);
    localparam logic [PWM_BITS-1:0] D_SPIN = PWM_BITS'(SPEED_SPIN);

    logic [4:0]          cmd_q;
    logic [PRESC_W-1:0]  presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                period_end;
    logic                force_stop;
    logic                cmd_illegal;
    logic                tgt_dir_l, tgt_dir_r;
    logic [PWM_BITS-1:0] tgt_duty_l, tgt_duty_r;

    assign tick       = (presc == PRESC_LAST);
    assign period_end = tick && (pwm_cnt == '1);

    always_comb begin
        force_stop  = 1'b0;
        cmd_illegal = 1'b0;
        tgt_dir_l   = DIR_FWD;
        tgt_dir_r   = DIR_FWD;
        tgt_duty_l  = '0;
        tgt_duty_r  = '0;
        case (cmd_q)
            MS_STOP:    force_stop = 1'b1;
            MS_FORWARD: begin
                tgt_duty_l = D_FWD;
                tgt_duty_r = D_FWD;
            end
            MS_RIGHT:   tgt_duty_l = D_TURN;
            MS_LEFT:    tgt_duty_r = D_TURN;
            MS_SPIN: begin
                tgt_duty_l = D_SPIN;
                tgt_dir_r  = DIR_REV;
                tgt_duty_r = D_SPIN;
            end
            default: begin
                force_stop  = 1'b1;
                cmd_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q   <= MS_STOP;
            presc   <= '0;
            pwm_cnt <= '0;
            pwm_l   <= 1'b0;
            pwm_r   <= 1'b0;
            fault   <= 1'b0;
        end else begin
            cmd_q <= motor_state;
            presc <= tick ? '0 : presc + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 1'b1;
            pwm_l <= (pwm_cnt < duty_l);
            pwm_r <= (pwm_cnt < duty_r);
            if (cmd_illegal)
                fault <= 1'b1;
        end
    end

    motor_channel #(
        .PWM_BITS(PWM_BITS), .STEP(STEP), .DEADTIME_PERIODS(DEADTIME_PERIODS)
    ) u_left (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .period_end(period_end),
        .force_stop(force_stop), .target_dir(tgt_dir_l), .target_duty(tgt_duty_l),
        .dir(dir_l), .duty(duty_l), .state(wheel_dbg.left)
    );

    motor_channel #(
        .PWM_BITS(PWM_BITS), .STEP(STEP), .DEADTIME_PERIODS(DEADTIME_PERIODS)
    ) u_right (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .period_end(period_end),
        .force_stop(force_stop), .target_dir(tgt_dir_r), .target_duty(tgt_duty_r),
        .dir(dir_r), .duty(duty_r), .state(wheel_dbg.right)
    );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver with a 16-clock PWM period; expectations follow MOTOR_RAMP_EN.
module tb_motor_pwm_driver;
    import motor_pkg::*;

    localparam int PERIOD = 16;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic [4:0] motor_state;
    logic       pwm_l, pwm_r, dir_l, dir_r, fault;
    logic [3:0] duty_l, duty_r;
    wheel_dbg_t wheel_dbg;

    int phase;
    int n_checks;
    int n_errors;
    logic [9:0] exp_q[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    motor_pwm_driver #(
        .CLKS_PER_TICK(1), .PWM_BITS(4), .SPEED_FWD(12), .SPEED_TURN(8),
        .SPEED_SPIN(6), .RAMP_STEP(4), .DEADTIME_PERIODS(2)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .motor_state(motor_state),
        .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
        .duty_l(duty_l), .duty_r(duty_r), .fault(fault), .wheel_dbg(wheel_dbg)
    );

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        phase++;
    endtask

    // Counter restarts at 0 on reset release, so every 16th edge is a period_end edge.
    task automatic next_period();
        tick();
        while (phase % PERIOD != 0) tick();
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic dl, input int ul, input logic dr, input int ur);
        exp_q.push_back({dl, ul[3:0], dr, ur[3:0]});
    endtask

    // Entry layout {dir_l, duty_l, dir_r, duty_r}, one entry per period_end.
    task automatic drain(input string tag);
        int i;
        logic [9:0] e;
        i = 0;
        while (exp_q.size() > 0) begin
            next_period();
            e = exp_q.pop_front();
            check_eq($sformatf("%s_p%0d", tag, i), 32'({dir_l, duty_l, dir_r, duty_r}), 32'(e));
            i++;
        end
    endtask

    task automatic check_idle(input string p);
        check_eq({p, "_duty_l"}, 32'(duty_l), 0);
        check_eq({p, "_duty_r"}, 32'(duty_r), 0);
        check_eq({p, "_pwm_l"}, 32'(pwm_l), 0);
        check_eq({p, "_pwm_r"}, 32'(pwm_r), 0);
        check_eq({p, "_dir_l"}, 32'(dir_l), 0);
        check_eq({p, "_dir_r"}, 32'(dir_r), 0);
        check_eq({p, "_fault"}, 32'(fault), 0);
        check_eq({p, "_wheel_state"}, 32'(wheel_dbg), 0);
    endtask

    initial begin
        int hi_l, hi_r, gap;
        n_checks = 0;
        n_errors = 0;
        phase = 0;
        reset_n = 1'b0;
        motor_state = MS_STOP;
        repeat (3) tick();
        check_idle("rst");

        motor_state = MS_FORWARD;
        reset_n = 1'b1;
        phase = 0;
`ifdef MOTOR_RAMP_EN
        push_exp(0, 4, 0, 4);   push_exp(0, 8, 0, 8);
        push_exp(0, 12, 0, 12); push_exp(0, 12, 0, 12);
`else
        push_exp(0, 12, 0, 12); push_exp(0, 12, 0, 12);
        push_exp(0, 12, 0, 12); push_exp(0, 12, 0, 12);
`endif
        drain("fwd");

        hi_l = 0;
        hi_r = 0;
        repeat (PERIOD) begin
            tick();
            hi_l += int'(pwm_l);
            hi_r += int'(pwm_r);
        end
        check_eq("pwm_l_high", hi_l, 12);
        check_eq("pwm_r_high", hi_r, 12);

        motor_state = MS_SPIN;
`ifdef MOTOR_RAMP_EN
        push_exp(0, 8, 0, 8); push_exp(0, 6, 0, 4); push_exp(0, 6, 0, 0);
        push_exp(0, 6, 0, 0); push_exp(0, 6, 1, 0); push_exp(0, 6, 1, 4);
        push_exp(0, 6, 1, 6);
`else
        push_exp(0, 6, 0, 0); push_exp(0, 6, 0, 0); push_exp(0, 6, 1, 0);
        push_exp(0, 6, 1, 6); push_exp(0, 6, 1, 6);
`endif
        drain("spin");

        // Assert reset between clock edges and look before the next edge arrives.
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("arst");
        repeat (2) tick();
        motor_state = MS_FORWARD;
        reset_n = 1'b1;
        phase = 0;
`ifdef MOTOR_RAMP_EN
        push_exp(0, 4, 0, 4); push_exp(0, 8, 0, 8);
`else
        push_exp(0, 12, 0, 12); push_exp(0, 12, 0, 12);
`endif
        drain("rfwd");

        motor_state = MS_STOP;
        tick();
`ifdef MOTOR_RAMP_EN
        check_eq("stop_hold", 32'(duty_l), 8);
`else
        check_eq("stop_hold", 32'(duty_l), 12);
`endif
        tick();
        check_eq("stop_duty_l", 32'(duty_l), 0);
        check_eq("stop_duty_r", 32'(duty_r), 0);
        tick();
        check_eq("stop_pwm_l", 32'(pwm_l), 0);
        check_eq("stop_pwm_r", 32'(pwm_r), 0);

        gap = $urandom_range(0, 6);
        repeat (gap) tick();
        motor_state = 5'b00011;
        repeat (3) tick();
        check_eq("ill_fault", 32'(fault), 1);
        check_eq("ill_duty_l", 32'(duty_l), 0);
        check_eq("ill_duty_r", 32'(duty_r), 0);
        motor_state = MS_FORWARD;
`ifdef MOTOR_RAMP_EN
        push_exp(0, 4, 0, 4); push_exp(0, 8, 0, 8);
`else
        push_exp(0, 12, 0, 12); push_exp(0, 12, 0, 12);
`endif
        drain("ill_fwd");
        check_eq("fault_sticky", 32'(fault), 1);

        #2;
        reset_n = 1'b0;
        #1;
        check_eq("fault_clr", 32'(fault), 0);
        tick();
        reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Downstream consumer of the robot FSM's one-hot 5-bit motor_state command.
- Turns each command into per-wheel PWM duty and direction for the H-bridge pins.
- Duty ramps smoothly toward each new target; a wheel that must reverse first brakes to zero and waits a dead-time.
- Invalid (non-one-hot) commands are treated as STOP and flagged.

Parameters:
- CLKS_PER_TICK, 50, CLOCK_50 cycles per PWM counter increment (prescaler); 1 is legal.
- PWM_BITS, 8, width of PWM counter and duty; period = 2^PWM_BITS ticks.
- SPEED_FWD, 200, duty for both wheels on FORWARD.
- SPEED_TURN, 140, duty of the driving wheel on LEFT/RIGHT.
- SPEED_SPIN, 120, duty of both wheels on SPIN.
- RAMP_STEP, 8, maximum duty change per PWM period.
- DEADTIME_PERIODS, 4, whole PWM periods at duty 0 before a direction flip.

Ports:
- CLOCK_50, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- motor_state, in, 5, one-hot command: 00001 STOP, 00010 FORWARD, 00100 RIGHT, 01000 LEFT, 10000 SPIN.
- pwm_l, out, 1, left-wheel PWM.
- pwm_r, out, 1, right-wheel PWM.
- dir_l, out, 1, left direction: 0 forward, 1 reverse.
- dir_r, out, 1, right direction: 0 forward, 1 reverse.
- duty_l, out, PWM_BITS, current left duty.
- duty_r, out, PWM_BITS, current right duty.
- fault, out, 1, sticky flag set by an illegal command.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, PWM counter 0, prescaler 0, both wheels in RUN, cmd_q = STOP.
- Command register: motor_state is registered into cmd_q every clock (1-cycle latency); the input is same-domain, no synchroniser.
- PWM counter and period_end:
  - PWM counter advances once every CLKS_PER_TICK clocks and wraps at 2^PWM_BITS-1.
  - period_end is a 1-cycle strobe on the clock where the counter wraps.
  - pwm_x is registered as (pwm_cnt < duty_x). Duty 0 gives constant low; maximum duty gives high for (2^PWM_BITS-1) of 2^PWM_BITS ticks.
- Targets {dir, duty} per command:
  - STOP: L {0,0}, R {0,0}.
  - FORWARD: L {0,SPEED_FWD}, R {0,SPEED_FWD}.
  - RIGHT: L {0,SPEED_TURN}, R {0,0}.
  - LEFT: L {0,0}, R {0,SPEED_TURN}.
  - SPIN: L {0,SPEED_SPIN}, R {1,SPEED_SPIN}.
  - Any non-one-hot value (including 0): STOP targets, and fault set to 1 until reset.
- STOP override:
  - When cmd_q is STOP or illegal, both duties clear to 0 on the next edge regardless of period_end or state.
  - pwm_x goes low on the following edge, i.e. no later than 3 edges after motor_state changes.
  - Wheel FSMs go to RUN with dir unchanged.
- Per-wheel FSM, updates only on period_end unless the STOP override applies:
  - RUN, target dir == dir: duty moves toward target by at most RAMP_STEP and saturates exactly at target (no overshoot, no unsigned wrap).
  - RUN, target dir != dir, duty > 0: go to BRAKE.
  - RUN, target dir != dir, duty == 0: go to DEAD.
  - BRAKE: duty decreases by RAMP_STEP, saturating at 0; at 0, go to DEAD and clear the dead counter.
  - DEAD: duty held at 0; count period_end strobes. After DEADTIME_PERIODS, latch the new dir and go to RUN; duty stays 0 in this period and begins ramping at the next period_end.
  - Target change during BRAKE/DEAD back to the original dir: return to RUN immediately at the next period_end and ramp from the current duty.
- Both wheels run independently; a simultaneous command change and period_end uses the new cmd_q only after it is registered.

Optional Feature:
- MOTOR_RAMP_EN defined: ramping as above.
- MOTOR_RAMP_EN undefined:
  - In RUN, duty jumps to target at the next period_end.
  - On a reversal, BRAKE is skipped: duty goes to 0 at period_end, then DEAD, then the new dir.
  - Dead-time and the STOP override are retained.

Decomposition:
- motor_pkg holds:
  - the motor_state_t enum (encodings above, shared with the robot FSM);
  - the wheel_state_t enum {RUN, BRAKE, DEAD};
  - DIR_FWD/DIR_REV constants.
- Sub-module motor_channel is instantiated twice (left, right). Inputs: target dir/duty, period_end, force_stop. Outputs: dir, duty. Prescaler, counter, command decode and fault live at top level.

Test Plan:
Bench parameters: CLKS_PER_TICK=1, PWM_BITS=4, SPEED_FWD=12, SPEED_TURN=8, SPEED_SPIN=6, RAMP_STEP=4, DEADTIME_PERIODS=2.
- Reset, then FORWARD: duty_l/duty_r = 4, 8, 12, 12 at successive period_ends; once settled, pwm_l is high 12 of every 16 clocks; dir 0.
- FORWARD settled, then SPIN:
  - duty_l goes 8, then 6.
  - duty_r goes 8, 4, 0, then stays 0 for 2 periods.
  - dir_r then becomes 1, duty_r stays 0 for that period, then goes 4, 6.
- FORWARD mid-ramp (duty 8), then STOP: duties 0 two edges after motor_state changes, pwm low by the third edge, no wait for period_end.
- motor_state=5'b00011: fault=1, duties 0; then FORWARD: normal ramp resumes, fault stays 1 until reset_n pulses low.
- Reset mid-operation:
  - reset_n asserted low mid-period: outputs 0 asynchronously, without waiting for a clock edge.
  - After release with FORWARD: first duty 4 at the first period_end.
- MOTOR_RAMP_EN undefined, STOP then FORWARD: duty 12 at the first period_end.
